// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative RV32M divider: widths, op codes,
// FSM state encoding and small decode helpers.
package div_unit_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 5;

    localparam logic [6:0]      FUNCT7_MULDIV = 7'b0000001;
    localparam logic [XLEN-1:0] XLEN_MIN      = {1'b1, {(XLEN-1){1'b0}}};

    // funct3[1:0] of the M-extension divide group
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } div_state_e;

    function automatic logic op_is_signed(input div_op_e op);
        return ~op[0];
    endfunction

    function automatic logic op_is_rem(input div_op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// Execute-stage <-> divider interface.
//   master : EX stage / hazard unit side (drives the request, sees stall/result)
//   slave  : divider side
interface div_unit_if;
    import div_unit_pkg::*;

    logic               div_start;
    div_op_e            div_op;
    logic [XLEN-1:0]    src_a;
    logic [XLEN-1:0]    src_b;
    logic               div_kill;
    logic               DivStalled;
    logic [XLEN-1:0]    div_result;
    logic               div_valid;

    modport master (
        output div_start, div_op, src_a, src_b, div_kill,
        input  DivStalled, div_result, div_valid
    );

    modport slave (
        input  div_start, div_op, src_a, src_b, div_kill,
        output DivStalled, div_result, div_valid
    );

endinterface

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift {rem,quo} left by one, trial-subtract
// the divisor from the partial remainder, and set the new quotient LSB when no
// borrow occurs.
// Ports:
//   i_rem, i_quo, i_divisor : current partial remainder / quotient / divisor
//   o_rem, o_quo            : values after this iteration
module div_unit_step
    import div_unit_pkg::*;
(
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;
    logic          w_borrow;

    // rem < divisor always holds, so the shifted value fits in XLEN+1 bits
    assign w_shift  = {i_rem, i_quo[XLEN-1]};
    assign w_diff   = w_shift - {1'b0, i_divisor};
    assign w_borrow = w_diff[XLEN];

    assign o_rem = w_borrow ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
    assign o_quo = {i_quo[XLEN-2:0], ~w_borrow};

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Holds the pipeline through DivStalled while an op is in flight and presents
// the sign-corrected result for one cycle with div_valid.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : div_unit_if.slave (start/op/operands/kill in, stall/result/valid out)
// Build option: DIV_EARLY_OUT_EN -- when defined, divide-by-zero and signed
// overflow finish in the issuing IDLE cycle without stalling.
module div_unit
    import div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    div_unit_if.slave   bus
);

    div_state_e         r_state;
    div_state_e         w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [XLEN-1:0]    r_rem;
    logic [XLEN-1:0]    r_quo;
    logic [XLEN-1:0]    r_divisor;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_is_rem;
    logic               r_dz;
    logic               r_ovf;

    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [XLEN-1:0]    w_abs_a;
    logic [XLEN-1:0]    w_abs_b;
    logic               w_dz;
    logic               w_ovf;
    logic               w_load;
    logic [XLEN-1:0]    w_step_rem;
    logic [XLEN-1:0]    w_step_quo;
    logic [XLEN-1:0]    w_quo_fix;
    logic [XLEN-1:0]    w_rem_fix;
    logic [XLEN-1:0]    w_done_result;

    // Operand decode for the IDLE-cycle capture
    assign w_signed = op_is_signed(bus.div_op);
    assign w_a_neg  = w_signed & bus.src_a[XLEN-1];
    assign w_b_neg  = w_signed & bus.src_b[XLEN-1];
    assign w_abs_a  = w_a_neg ? XLEN'(0) - bus.src_a : bus.src_a;
    assign w_abs_b  = w_b_neg ? XLEN'(0) - bus.src_b : bus.src_b;
    assign w_dz     = (bus.src_b == '0);
    assign w_ovf    = w_signed & (bus.src_a == XLEN_MIN) & (bus.src_b == '1);

    div_unit_step u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_divisor),
        .o_rem     (w_step_rem),
        .o_quo     (w_step_quo)
    );

    // Sign correction, then architected overrides for the special cases
    always_comb begin
        w_quo_fix = r_neg_q ? XLEN'(0) - r_quo : r_quo;
        w_rem_fix = r_neg_r ? XLEN'(0) - r_rem : r_rem;
        if (r_dz) begin
            w_quo_fix = '1;
        end
        if (r_ovf) begin
            w_quo_fix = XLEN_MIN;
            w_rem_fix = '0;
        end
        w_done_result = r_is_rem ? w_rem_fix : w_quo_fix;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and outputs; kill overrides everything except the stall
    always_comb begin
        w_next_state   = r_state;
        w_load         = 1'b0;
        bus.DivStalled = 1'b0;
        bus.div_valid  = 1'b0;
        bus.div_result = '0;

        unique case (r_state)
            IDLE: begin
                if (bus.div_start && !bus.div_kill) begin
`ifdef DIV_EARLY_OUT_EN
                    if (w_dz || w_ovf) begin
                        bus.div_valid = 1'b1;
                        if (op_is_rem(bus.div_op)) begin
                            bus.div_result = w_dz ? bus.src_a : '0;
                        end else begin
                            bus.div_result = w_dz ? '1 : XLEN_MIN;
                        end
                    end else begin
                        bus.DivStalled = 1'b1;
                        w_load         = 1'b1;
                        w_next_state   = BUSY;
                    end
`else
                    bus.DivStalled = 1'b1;
                    w_load         = 1'b1;
                    w_next_state   = BUSY;
`endif
                end
            end
            BUSY: begin
                bus.DivStalled = 1'b1;
                if (r_cnt == '0) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                bus.div_valid  = 1'b1;
                bus.div_result = w_done_result;
                w_next_state   = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase

        if (bus.div_kill) begin
            w_next_state   = IDLE;
            w_load         = 1'b0;
            bus.div_valid  = 1'b0;
            bus.div_result = '0;
        end
    end

    // Datapath: capture magnitudes in IDLE, iterate in BUSY
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_is_rem  <= 1'b0;
            r_dz      <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (w_load) begin
            r_cnt     <= CNT_W'(XLEN - 1);
            r_rem     <= '0;
            r_quo     <= w_abs_a;
            r_divisor <= w_abs_b;
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
            r_is_rem  <= op_is_rem(bus.div_op);
            r_dz      <= w_dz;
            r_ovf     <= w_ovf;
        end else if (r_state == BUSY && !bus.div_kill) begin
            r_rem <= w_step_rem;
            r_quo <= w_step_quo;
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver issues ops and queues the expected
// result from a plain-arithmetic RV32M model; a monitor pops on div_valid.
module tb_div_unit;
    import div_unit_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [31:0] exp_q[$];

    div_unit_if bus();

    div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // RV32M reference semantics
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            2'b00:   return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
            2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10:   return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_stalls(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
        if (b == 0) return 0;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
`endif
        return 33;
    endfunction

    // Called at posedge+1; returns at posedge+1 of the cycle after div_valid
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int stalls;
        int lat;
        bit seen;
        int es;
        es = exp_stalls(op, a, b);
        bus.div_start = 1'b1;
        bus.div_op    = div_op_e'(op);
        bus.src_a     = a;
        bus.src_b     = b;
        exp_q.push_back(ref_result(op, a, b));
        stalls = 0;
        lat    = 0;
        seen   = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (bus.DivStalled) stalls++;
            if (bus.div_valid) begin
                seen = 1'b1;
                lat  = c;
            end
            @(posedge clk);
            #1;
            bus.div_start = 1'b0;
            bus.src_a     = $urandom;
            bus.src_b     = $urandom;
        end
        check("valid_seen", 32'(seen), 32'd1);
        check("stall_cycles", 32'(stalls), 32'(es));
        check("latency", 32'(lat), 32'(es));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every valid must match the oldest queued expectation
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.div_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_valid", 32'd1, 32'd0);
                    end else begin
                        check("result", bus.div_result, exp_q.pop_front());
                    end
                end else begin
                    check("result_zero_when_invalid", bus.div_result, 32'h0);
                end
            end
        end
    end

    initial begin
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.div_start = 1'b0;
        bus.div_op    = OP_DIV;
        bus.src_a     = '0;
        bus.src_b     = '0;
        bus.div_kill  = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_stall", 32'(bus.DivStalled), 32'd0);
        check("reset_valid", 32'(bus.div_valid), 32'd0);
        check("reset_result", bus.div_result, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic unsigned, signed sign rules, special cases
        run_op(2'b01, 32'd100, 32'd7);
        run_op(2'b11, 32'd100, 32'd7);
        run_op(2'b00, -32'sd7, 32'd2);
        run_op(2'b10, -32'sd7, 32'd2);
        run_op(2'b10, 32'd7, -32'sd2);
        run_op(2'b01, 32'h1234, 32'h0);
        run_op(2'b11, 32'h1234, 32'h0);
        run_op(2'b00, 32'hFFFF_FFF0, 32'h0);
        run_op(2'b10, 32'hFFFF_FFF0, 32'h0);
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(2);

        // Synchronous reset in the middle of BUSY
        bus.div_start = 1'b1;
        bus.div_op    = OP_DIVU;
        bus.src_a     = 32'd5000;
        bus.src_b     = 32'd3;
        idle(1);
        bus.div_start = 1'b0;
        idle(9);
        rst = 1'b1;
        @(negedge clk);
        check("stall_during_busy", 32'(bus.DivStalled), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_stall", 32'(bus.DivStalled), 32'd0);
        check("post_reset_valid", 32'(bus.div_valid), 32'd0);
        @(posedge clk);
        #1;
        run_op(2'b01, 32'd9, 32'd3);
        idle(1);

        // Kill in BUSY: stall held this cycle, dropped next, never a valid
        bus.div_start = 1'b1;
        bus.div_op    = OP_DIVU;
        bus.src_a     = 32'd1000;
        bus.src_b     = 32'd7;
        idle(1);
        bus.div_start = 1'b0;
        idle(4);
        bus.div_kill = 1'b1;
        @(negedge clk);
        check("kill_cycle_stall", 32'(bus.DivStalled), 32'd1);
        check("kill_cycle_valid", 32'(bus.div_valid), 32'd0);
        @(posedge clk);
        #1;
        bus.div_kill = 1'b0;
        @(negedge clk);
        check("after_kill_stall", 32'(bus.DivStalled), 32'd0);
        check("after_kill_valid", 32'(bus.div_valid), 32'd0);
        @(posedge clk);
        #1;
        idle(40);

        // Back-to-back: second start in the IDLE cycle right after DONE
        run_op(2'b01, 32'd10, 32'd3);
        run_op(2'b01, 32'd20, 32'd4);

        // Randomized ops, mixing ordinary, small, zero and overflow divisors
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'h0;
                1: b = 32'($urandom_range(1, 15));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: begin a = 32'($urandom_range(0, 1000)); b = $urandom; end
                default: b = $urandom;
            endcase
            run_op(op, a, b);
        end

        idle(3);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
